// File: rtl/key_pkg.sv
// Shared default constants for key debouncing. The bank and other key consumers
// take their timing defaults from here so they stay consistent.
package key_pkg;
    localparam int KEY_STABLE_DEFAULT = 2424832;
    localparam int KEY_HOLD_DEFAULT   = 50000000;
    localparam int KEY_REPEAT_DEFAULT = 0;
    localparam int KEY_CNT_W          = 23;
    localparam int KEY_HOLD_W         = 26;
endpackage

// File: rtl/key_debounce_bank_if.sv
// Key bank bundle: raw pins in, debounced level and event pulses out.
// The master side is the pin/consumer environment; the slave side is the debouncer.
interface key_debounce_bank_if #(
    parameter int NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] key_in;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic [NUM_KEYS-1:0] key_hold;

    modport master (output key_in, input key_level, key_press, key_release, key_hold);
    modport slave  (input key_in, output key_level, key_press, key_release, key_hold);
endinterface

// File: rtl/key_debounce_chan.sv
// One key channel: 2-FF synchroniser, stability counter, registered press/release
// pulses, and hold detection with optional auto-repeat.
module key_debounce_chan
    import key_pkg::*;
#(
    parameter int ACTIVE_LOW    = 1,
    parameter int STABLE_CYCLES = KEY_STABLE_DEFAULT,
    parameter int CNT_W         = KEY_CNT_W,
    parameter int HOLD_CYCLES   = KEY_HOLD_DEFAULT,
    parameter int REPEAT_CYCLES = KEY_REPEAT_DEFAULT,
    parameter int HOLD_W        = KEY_HOLD_W
) (
    input  logic clk,
    input  logic rst,
    input  logic key_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic hold_o
);
    localparam logic              AL          = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0]  STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REP_LAST    = HOLD_W'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);

    logic [1:0]        sync_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [HOLD_W-1:0] hcnt_q;
    logic              level_q, press_q, release_q, hold_q;
    logic              rep_q, done_q;
    logic              s, chg_now, rel_now;
    logic [HOLD_W-1:0] hold_thr;

    // s is the synchronised pin normalised so that 1 means pressed
    assign s        = sync_q[1] ^ AL;
    assign chg_now  = (s != level_q) && (cnt_q == STABLE_LAST);
    assign rel_now  = chg_now && level_q;
    assign hold_thr = rep_q ? REP_LAST : HOLD_LAST;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= {2{AL}};
            cnt_q     <= '0;
            hcnt_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            hold_q    <= 1'b0;
            rep_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], key_i};
            press_q   <= 1'b0;
            release_q <= 1'b0;
            hold_q    <= 1'b0;

            if (s == level_q) begin
                cnt_q <= '0;
            end else if (chg_now) begin
                cnt_q     <= '0;
                level_q   <= s;
                press_q   <= s;
                release_q <= ~s;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end

            // A release due this cycle suppresses any hold pulse due on the same edge
            if (!level_q || rel_now) begin
                hcnt_q <= '0;
                rep_q  <= 1'b0;
                done_q <= 1'b0;
            end else if (hcnt_q == hold_thr) begin
                if (!done_q) hold_q <= 1'b1;
                if (REPEAT_CYCLES == 0) begin
                    done_q <= 1'b1;
                end else begin
                    hcnt_q <= '0;
                    rep_q  <= 1'b1;
                end
            end else begin
                hcnt_q <= hcnt_q + 1'b1;
            end
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign hold_o    = hold_q;
endmodule

// File: rtl/key_debounce_bank.sv
// Multi-channel key debouncer: NUM_KEYS independent key_debounce_chan instances
// with no shared state.
module key_debounce_bank
    import key_pkg::*;
#(
    parameter int NUM_KEYS      = 4,
    parameter int ACTIVE_LOW    = 1,
    parameter int STABLE_CYCLES = KEY_STABLE_DEFAULT,
    parameter int CNT_W         = KEY_CNT_W,
    parameter int HOLD_CYCLES   = KEY_HOLD_DEFAULT,
    parameter int REPEAT_CYCLES = KEY_REPEAT_DEFAULT,
    parameter int HOLD_W        = KEY_HOLD_W
) (
    input  logic                clk,
    input  logic                rst,
    key_debounce_bank_if.slave  kif
);
    localparam longint HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;

    if (NUM_KEYS < 1) begin : g_chk_keys
        $error("key_debounce_bank: NUM_KEYS must be >= 1");
    end
    if (ACTIVE_LOW != 0 && ACTIVE_LOW != 1) begin : g_chk_pol
        $error("key_debounce_bank: ACTIVE_LOW must be 0 or 1");
    end
    if (STABLE_CYCLES < 2) begin : g_chk_stable
        $error("key_debounce_bank: STABLE_CYCLES must be >= 2");
    end
    if (longint'(STABLE_CYCLES) >= (longint'(1) << CNT_W)) begin : g_chk_cnt_w
        $error("key_debounce_bank: STABLE_CYCLES must be < 2**CNT_W");
    end
    if (HOLD_CYCLES < 1) begin : g_chk_hold
        $error("key_debounce_bank: HOLD_CYCLES must be >= 1");
    end
    if (REPEAT_CYCLES < 0) begin : g_chk_rep
        $error("key_debounce_bank: REPEAT_CYCLES must be >= 0");
    end
    if (HOLD_MAX >= (longint'(1) << HOLD_W)) begin : g_chk_hold_w
        $error("key_debounce_bank: max(HOLD_CYCLES,REPEAT_CYCLES) must be < 2**HOLD_W");
    end

    logic [NUM_KEYS-1:0] level, press, release_p, hold;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
        key_debounce_chan #(
            .ACTIVE_LOW    (ACTIVE_LOW),
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_W         (CNT_W),
            .HOLD_CYCLES   (HOLD_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES),
            .HOLD_W        (HOLD_W)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .key_i     (kif.key_in[g]),
            .level_o   (level[g]),
            .press_o   (press[g]),
            .release_o (release_p[g]),
            .hold_o    (hold[g])
        );
    end

    assign kif.key_level   = level;
    assign kif.key_press   = press;
    assign kif.key_release = release_p;
    assign kif.key_hold    = hold;
endmodule

// File: tb/tb_key_debounce_bank.sv
// Directed bench for key_debounce_bank with short sim timing (STABLE=8, HOLD=32, REPEAT=8).
// Expected pulse cycles are hand-derived: pin edge to level/pulse is 2 + STABLE_CYCLES clocks.
module tb_key_debounce_bank;
    localparam int NK = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    key_debounce_bank_if #(.NUM_KEYS(NK)) kif ();

    key_debounce_bank #(
        .NUM_KEYS      (NK),
        .ACTIVE_LOW    (1),
        .STABLE_CYCLES (8),
        .CNT_W         (4),
        .HOLD_CYCLES   (32),
        .REPEAT_CYCLES (8),
        .HOLD_W        (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kif (kif)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled and inputs driven 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] outs;
        kif.key_in = 4'hF;
        rst = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            outs = {kif.key_level, kif.key_press, kif.key_release, kif.key_hold};
            n_cmp++;
            if (outs !== 16'h0) begin
                n_bad++;
                $display("FAIL reset_hold k=%0d outs=%h expected=0000", k, outs);
            end
        end
        rst = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            step();
            outs = {kif.key_level, kif.key_press, kif.key_release, kif.key_hold};
            n_cmp++;
            if (outs !== 16'h0) begin
                n_bad++;
                $display("FAIL reset_release k=%0d outs=%h expected=0000", k, outs);
            end
        end
    endtask

    task automatic test_clean_press();
        kif.key_in = 4'b1110;
        for (int k = 1; k <= 20; k++) begin
            step();
            n_cmp++;
            if (kif.key_press !== ((k == 10) ? 4'b0001 : 4'b0000)) begin
                n_bad++;
                $display("FAIL clean_press k=%0d press=%b", k, kif.key_press);
            end
            n_cmp++;
            if (kif.key_level !== ((k >= 10) ? 4'b0001 : 4'b0000)) begin
                n_bad++;
                $display("FAIL clean_level k=%0d level=%b", k, kif.key_level);
            end
        end
        kif.key_in = 4'hF;
        for (int k = 1; k <= 12; k++) begin
            step();
            n_cmp++;
            if (kif.key_release !== ((k == 10) ? 4'b0001 : 4'b0000)) begin
                n_bad++;
                $display("FAIL clean_release k=%0d release=%b", k, kif.key_release);
            end
            n_cmp++;
            if (kif.key_level !== ((k >= 10) ? 4'b0000 : 4'b0001)) begin
                n_bad++;
                $display("FAIL clean_rel_level k=%0d level=%b", k, kif.key_level);
            end
        end
    endtask

    task automatic test_bounce();
        for (int seg = 0; seg < 8; seg++) begin
            kif.key_in[1] = seg[0];
            for (int k = 0; k < 5; k++) begin
                step();
                n_cmp++;
                if ({kif.key_press, kif.key_level} !== 8'h00) begin
                    n_bad++;
                    $display("FAIL bounce_quiet seg=%0d press=%b level=%b", seg, kif.key_press, kif.key_level);
                end
            end
        end
        kif.key_in[1] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            n_cmp++;
            if (kif.key_press !== ((k == 10) ? 4'b0010 : 4'b0000)) begin
                n_bad++;
                $display("FAIL bounce_press k=%0d press=%b", k, kif.key_press);
            end
        end
        kif.key_in[1] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            n_cmp++;
            if ({kif.key_release, kif.key_hold} !== {((k == 10) ? 4'b0010 : 4'b0000), 4'b0000}) begin
                n_bad++;
                $display("FAIL bounce_release k=%0d release=%b hold=%b", k, kif.key_release, kif.key_hold);
            end
        end
    endtask

    task automatic test_glitch();
        kif.key_in[2] = 1'b0;
        for (int k = 1; k <= 7; k++) step();
        kif.key_in[2] = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            step();
            n_cmp++;
            if ({kif.key_press, kif.key_level} !== 8'h00) begin
                n_bad++;
                $display("FAIL glitch k=%0d press=%b level=%b", k, kif.key_press, kif.key_level);
            end
        end
    endtask

    task automatic test_hold_repeat();
        logic exp_hold;
        kif.key_in[3] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            n_cmp++;
            if (kif.key_press !== ((k == 10) ? 4'b1000 : 4'b0000)) begin
                n_bad++;
                $display("FAIL hold_press k=%0d press=%b", k, kif.key_press);
            end
        end
        // Pin released at P+62 so the release lands at P+72, exactly when a repeat is due
        for (int k = 1; k <= 72; k++) begin
            step();
            exp_hold = (k == 32) || (k == 40) || (k == 48) || (k == 56) || (k == 64);
            n_cmp++;
            if (kif.key_hold !== {exp_hold, 3'b000}) begin
                n_bad++;
                $display("FAIL hold_pulse k=%0d hold=%b expected=%b", k, kif.key_hold, {exp_hold, 3'b000});
            end
            n_cmp++;
            if (kif.key_release !== ((k == 72) ? 4'b1000 : 4'b0000)) begin
                n_bad++;
                $display("FAIL hold_release k=%0d release=%b", k, kif.key_release);
            end
            if (k == 62) kif.key_in[3] = 1'b1;
        end
        for (int k = 1; k <= 20; k++) begin
            step();
            n_cmp++;
            if ({kif.key_hold, kif.key_level} !== 8'h00) begin
                n_bad++;
                $display("FAIL hold_after_release k=%0d hold=%b level=%b", k, kif.key_hold, kif.key_level);
            end
        end
    endtask

    task automatic test_simultaneous();
        kif.key_in = 4'b0111;
        for (int k = 1; k <= 10; k++) step();
        n_cmp++;
        if (kif.key_level !== 4'b1000) begin
            n_bad++;
            $display("FAIL simul_setup level=%b expected=1000", kif.key_level);
        end
        kif.key_in = 4'b1110;
        for (int k = 1; k <= 12; k++) begin
            step();
            n_cmp++;
            if ({kif.key_press, kif.key_release} !== ((k == 10) ? 8'b0001_1000 : 8'h00)) begin
                n_bad++;
                $display("FAIL simul_edges k=%0d press=%b release=%b", k, kif.key_press, kif.key_release);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [15:0] outs;
        kif.key_in = 4'hF;
        for (int k = 1; k <= 10; k++) step();
        n_cmp++;
        if (kif.key_release !== 4'b0001) begin
            n_bad++;
            $display("FAIL midrst_setup release=%b expected=0001", kif.key_release);
        end
        kif.key_in = 4'hE;
        // After 7 clocks the ch0 stability counter sits at 5
        for (int k = 1; k <= 7; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        outs = {kif.key_level, kif.key_press, kif.key_release, kif.key_hold};
        n_cmp++;
        if (outs !== 16'h0) begin
            n_bad++;
            $display("FAIL midrst_outs outs=%h expected=0000", outs);
        end
        for (int k = 1; k <= 12; k++) begin
            step();
            n_cmp++;
            if (kif.key_press !== ((k == 10) ? 4'b0001 : 4'b0000)) begin
                n_bad++;
                $display("FAIL midrst_press k=%0d press=%b", k, kif.key_press);
            end
            n_cmp++;
            if (kif.key_level !== ((k >= 10) ? 4'b0001 : 4'b0000)) begin
                n_bad++;
                $display("FAIL midrst_level k=%0d level=%b", k, kif.key_level);
            end
        end
    endtask

    initial begin
        kif.key_in = 4'hF;
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_hold_repeat();
        test_simultaneous();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
